// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_pkg                                                    |
// | Purpose : Shared CPU encodings: 4-bit ALU opcodes carried in the     |
// |           instruction word, memory row encodings, and ALU function   |
// |           codes.                                                     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // ALU opcodes (IR[OPC_LSB+3:OPC_LSB])
  localparam logic [3:0] ALU_LW   = 4'b0000;
  localparam logic [3:0] ALU_SW   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_BGE  = 4'b0111;
  localparam logic [3:0] ALU_J    = 4'b1000;
  localparam logic [3:0] ALU_ADDI = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_MULI = 4'b1101;

  // Memory operation presented to the MEM stage
  typedef logic [1:0] row_t;
  localparam row_t ROW_NOP = 2'b00;
  localparam row_t ROW_RD  = 2'b01;
  localparam row_t ROW_WR  = 2'b10;

  // ALU function codes used by the execute stage
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

endpackage
`default_nettype wire

// File: rtl/ex_mem_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ex_mem_decode                                              |
// | Purpose : Combinational decode of an incoming EX bundle into the     |
// |           memory row (nop/read/write) and the taken flag for J/BGE.  |
// | Ports   : ir_i     instruction word                                  |
// |           data1_i  ALU result / BGE compare operand (signed)         |
// |           row_o    ROW_NOP / ROW_RD / ROW_WR                         |
// |           taken_o  1 when the bundle redirects fetch                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ex_mem_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 28
) (
  input  logic [IR_W-1:0]   ir_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [1:0]        row_o,
  output logic              taken_o
);

  logic [3:0] w_opc;
  logic       w_unused;

  assign w_opc = ir_i[OPC_LSB+3:OPC_LSB];

  // Only the opcode field and the sign of data1 matter here.
  assign w_unused = ^{ir_i, data1_i};

  always_comb begin
    row_o   = ROW_NOP;
    taken_o = 1'b0;
    case (w_opc)
      ALU_LW:  row_o   = ROW_RD;
      ALU_SW:  row_o   = ROW_WR;
      ALU_J:   taken_o = 1'b1;
      // Signed data1 >= 0 is simply a clear sign bit.
      ALU_BGE: taken_o = ~data1_i[DATA_W-1];
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ex_mem_pipe                                                |
// | Purpose : EX->MEM pipeline stage with valid/ready on both sides, a   |
// |           two-entry (main + skid) buffer, flush, memory-op decode    |
// |           and a one-cycle redirect pulse for taken J/BGE.            |
// | Ports   : clk_i, rst_n_i (async, active-low)                         |
// |           in_valid_i/in_ready_o, data1_i, data2_i, IR_i  (from EX)   |
// |           flush_i                                                    |
// |           out_valid_o/out_ready_i, data1_o, data2_o, IR_o, row_o     |
// |           redirect_o, redirect_target_o  (toward fetch)              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ex_mem_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 28
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IR_W-1:0]   IR_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [IR_W-1:0]   IR_o,
  output logic [1:0]        row_o,
  output logic              redirect_o,
  output logic [DATA_W-1:0] redirect_target_o
);

  // Main entry (drives the outputs)
  logic              r_vm;
  logic [DATA_W-1:0] r_m_data1;
  logic [DATA_W-1:0] r_m_data2;
  logic [IR_W-1:0]   r_m_ir;
  logic [1:0]        r_m_row;
  logic              r_m_taken;

  // Skid entry
  logic              r_vs;
  logic [DATA_W-1:0] r_s_data1;
  logic [DATA_W-1:0] r_s_data2;
  logic [IR_W-1:0]   r_s_ir;
  logic [1:0]        r_s_row;
  logic              r_s_taken;

  logic              r_in_ready;
  logic              r_redirect;
  logic [DATA_W-1:0] r_target;

  logic [1:0]        w_row;
  logic              w_taken;
  logic [DATA_W-1:0] w_store_d1;
  logic              w_push;
  logic              w_pop;
  logic              w_vm_nxt;
  logic              w_vs_nxt;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid;
  logic              w_unused;

  ex_mem_decode #(
    .DATA_W  (DATA_W),
    .IR_W    (IR_W),
    .OPC_LSB (OPC_LSB)
  ) u_decode (
    .ir_i    (IR_i),
    .data1_i (data1_i),
    .row_o   (w_row),
    .taken_o (w_taken)
  );

  // A taken bundle carries its target in the data1 slot downstream.
  assign w_store_d1 = w_taken ? data2_i : data1_i;

  // A bundle handed over during flush is dropped as if never offered.
  assign w_push = in_valid_i && r_in_ready && !flush_i;
  assign w_pop  = r_vm && out_ready_i;

  always_comb begin
    w_vm_nxt       = r_vm;
    w_vs_nxt       = r_vs;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush_i) begin
      w_vm_nxt = 1'b0;
      w_vs_nxt = 1'b0;
    end else if (!r_vm || (w_pop && !r_vs)) begin
      // Main empty or draining with nothing behind it: input goes to main.
      w_vm_nxt     = w_push;
      w_ld_main_in = w_push;
    end else if (w_pop) begin
      // Main draining with skid full: skid advances, new bundle refills skid.
      w_vm_nxt       = 1'b1;
      w_ld_main_skid = 1'b1;
      w_vs_nxt       = w_push;
      w_ld_skid      = w_push;
    end else if (w_push) begin
      // Main held: park the new bundle in skid.
      w_vs_nxt  = 1'b1;
      w_ld_skid = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vm       <= 1'b0;
      r_vs       <= 1'b0;
      r_m_data1  <= '0;
      r_m_data2  <= '0;
      r_m_ir     <= '0;
      r_m_row    <= ROW_NOP;
      r_m_taken  <= 1'b0;
      r_s_data1  <= '0;
      r_s_data2  <= '0;
      r_s_ir     <= '0;
      r_s_row    <= ROW_NOP;
      r_s_taken  <= 1'b0;
      r_in_ready <= 1'b1;
      r_redirect <= 1'b0;
      r_target   <= '0;
    end else begin
      r_vm       <= w_vm_nxt;
      r_vs       <= w_vs_nxt;
      r_in_ready <= !w_vs_nxt;
      r_redirect <= w_push && w_taken;
      if (w_push && w_taken) begin
        r_target <= data2_i;
      end
      if (w_ld_main_in) begin
        r_m_data1 <= w_store_d1;
        r_m_data2 <= data2_i;
        r_m_ir    <= IR_i;
        r_m_row   <= w_row;
        r_m_taken <= w_taken;
      end else if (w_ld_main_skid) begin
        r_m_data1 <= r_s_data1;
        r_m_data2 <= r_s_data2;
        r_m_ir    <= r_s_ir;
        r_m_row   <= r_s_row;
        r_m_taken <= r_s_taken;
      end
      if (w_ld_skid) begin
        r_s_data1 <= w_store_d1;
        r_s_data2 <= data2_i;
        r_s_ir    <= IR_i;
        r_s_row   <= w_row;
        r_s_taken <= w_taken;
      end
    end
  end

  // The taken flag travels with each entry for downstream visibility only.
  assign w_unused = r_m_taken ^ r_s_taken;

  assign in_ready_o        = r_in_ready;
  assign out_valid_o       = r_vm;
  assign data1_o           = r_m_data1;
  assign data2_o           = r_m_data2;
  assign IR_o              = r_m_ir;
  assign row_o             = r_m_row;
  assign redirect_o        = r_redirect;
  assign redirect_target_o = r_target;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ex_mem_pipe                                             |
// | Purpose : Self-checking scoreboard bench for ex_mem_pipe.            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int IR_W   = 32;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] ir;
    logic [1:0]  row;
  } bundle_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic [IR_W-1:0]   IR_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data1_o;
  logic [DATA_W-1:0] data2_o;
  logic [IR_W-1:0]   IR_o;
  logic [1:0]        row_o;
  logic              redirect_o;
  logic [DATA_W-1:0] redirect_target_o;

  bundle_t     q[$];
  int          n_err = 0;
  int          n_chk = 0;
  logic        exp_redir = 1'b0;
  logic [31:0] exp_tgt = '0;

  ex_mem_pipe #(.DATA_W(32), .IR_W(32), .OPC_LSB(28)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .data1_i           (data1_i),
    .data2_i           (data2_i),
    .IR_i              (IR_i),
    .flush_i           (flush_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .data1_o           (data1_o),
    .data2_o           (data2_o),
    .IR_o              (IR_o),
    .row_o             (row_o),
    .redirect_o        (redirect_o),
    .redirect_target_o (redirect_target_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic is_taken(input logic [31:0] d1, input logic [31:0] ir);
    case (ir[31:28])
      4'b1000: return 1'b1;
      4'b0111: return ($signed(d1) >= 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bundle_t model(input logic [31:0] d1, input logic [31:0] d2,
                                    input logic [31:0] ir);
    bundle_t b;
    b.d1  = is_taken(d1, ir) ? d2 : d1;
    b.d2  = d2;
    b.ir  = ir;
    b.row = (ir[31:28] == 4'b0000) ? 2'b01 :
            (ir[31:28] == 4'b0001) ? 2'b10 : 2'b00;
    return b;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] ir);
    in_valid_i = v;
    data1_i    = d1;
    data2_i    = d2;
    IR_i       = ir;
  endtask

  // One clock: score the output handshake, book the input handshake,
  // then check state just after the edge.
  task automatic cycle();
    logic    acc;
    logic    pop;
    bundle_t e;
    acc = in_valid_i && in_ready_o && !flush_i;
    pop = out_valid_o && out_ready_i;
    if (pop && !flush_i) begin
      if (q.size() == 0) begin
        check("pop_unexpected", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("data1_o", data1_o, e.d1);
        check("data2_o", data2_o, e.d2);
        check("IR_o", IR_o, e.ir);
        check("row_o", row_o, e.row);
      end
    end
    if (flush_i) q.delete();
    else if (acc) q.push_back(model(data1_i, data2_i, IR_i));
    exp_redir = acc && is_taken(data1_i, IR_i);
    if (exp_redir) exp_tgt = data2_i;
    @(posedge clk_i);
    #1;
    check("redirect_o", redirect_o, exp_redir);
    check("redirect_target_o", redirect_target_o, exp_tgt);
    check("out_valid_o", out_valid_o, q.size() != 0);
    check("in_ready_o", in_ready_o, q.size() < 2);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [3:0] opcs [5];
    opcs[0] = 4'b0000; opcs[1] = 4'b0001; opcs[2] = 4'b0010;
    opcs[3] = 4'b0111; opcs[4] = 4'b1000;
    return {opcs[$urandom_range(0, 4)], 28'($urandom)};
  endfunction

  initial begin
    rst_n_i     = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    #12;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_redirect", redirect_o, 0);
    check("rst_row", row_o, 0);
    check("rst_data1", data1_o, 0);
    check("rst_target", redirect_target_o, 0);
    rst_n_i = 1'b1;

    // First push after reset: LW, one-cycle latency
    drive(1'b1, 32'h40, 32'h0, 32'h0000_0000);
    cycle();
    check("lw_valid", out_valid_o, 1);
    check("lw_row", row_o, 2'b01);
    check("lw_data1", data1_o, 32'h40);
    drive(1'b0, '0, '0, '0);
    cycle();

    // Back-pressure: SW then ADDU fill both entries
    out_ready_i = 1'b0;
    drive(1'b1, 32'h11, 32'h22, 32'h1000_0005);
    cycle();
    drive(1'b1, 32'h33, 32'h44, 32'h2000_0006);
    cycle();
    check("bp_full_ready", in_ready_o, 0);
    drive(1'b0, '0, '0, '0);
    out_ready_i = 1'b1;
    cycle();
    check("bp_ready_back", in_ready_o, 1);
    check("bp_second_row", row_o, 2'b00);
    cycle();

    // BGE negative: not taken; BGE zero: taken; J: taken
    drive(1'b1, 32'hFFFF_FFFF, 32'h100, 32'h7000_0000);
    cycle();
    check("bge_neg_d1", data1_o, 32'hFFFF_FFFF);
    drive(1'b1, 32'h0, 32'h100, 32'h7000_0001);
    cycle();
    check("bge_zero_d1", data1_o, 32'h100);
    drive(1'b1, 32'h5, 32'h200, 32'h8000_0000);
    cycle();
    check("j_target", redirect_target_o, 32'h200);
    drive(1'b0, '0, '0, '0);
    cycle();
    cycle();

    // Flush with both entries full and a J offered
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1, 32'h2, 32'h2000_0001);
    cycle();
    drive(1'b1, 32'h3, 32'h4, 32'h3000_0002);
    cycle();
    drive(1'b1, 32'h0, 32'h300, 32'h8000_0000);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check("flush_valid", out_valid_o, 0);
    check("flush_ready", in_ready_o, 1);
    check("flush_no_redir", redirect_o, 0);
    // Flush with room available: the J handshake is dropped
    drive(1'b1, 32'h7, 32'h8, 32'h2000_0003);
    cycle();
    drive(1'b1, 32'h0, 32'h400, 32'h8000_0000);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    cycle();
    // Redirect already in flight when flush arrives still completes
    out_ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'h500, 32'h8000_0000);
    cycle();
    check("inflight_redir", redirect_o, 1);
    drive(1'b0, '0, '0, '0);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;

    // Asynchronous reset mid-stream with both entries full
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA, 32'hB, 32'h0000_0001);
    cycle();
    drive(1'b1, 32'hC, 32'hD, 32'h1000_0001);
    cycle();
    drive(1'b0, '0, '0, '0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_ready", in_ready_o, 1);
    check("arst_target", redirect_target_o, 0);
    #1;
    rst_n_i = 1'b1;
    q.delete();
    exp_tgt = '0;
    out_ready_i = 1'b1;
    cycle();
    cycle();

    // Full-rate streaming, then random traffic with random back-pressure
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, $urandom, rand_ir());
      cycle();
    end
    for (int i = 0; i < 80; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, rand_ir());
      cycle();
    end
    drive(1'b0, '0, '0, '0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 5 && q.size() != 0; i++) cycle();
    check("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage with a valid/ready handshake on both sides, a two-entry skid buffer, and a pipeline flush. It captures the ALU results and the instruction word, decodes the memory operation (read/write/nop), and resolves J/BGE into a one-cycle redirect pulse toward fetch. It sits between the execute stage and the data-memory stage and replaces the free-running EX/MEM latch.

## Interface
Parameters:
- DATA_W, 32, width of data1/data2 and of the redirect target
- IR_W, 32, instruction word width
- OPC_LSB, 28, LSB of the opcode field in IR; the opcode is IR[OPC_LSB+3:OPC_LSB]

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  execute stage presents a bundle
- in_ready_o  out  1  stage can accept; registered
- data1_i  in  DATA_W  ALU result / compare operand
- data2_i  in  DATA_W  store data / branch target
- IR_i  in  IR_W  instruction word
- flush_i  in  1  discard all held and incoming bundles
- out_valid_o  out  1  bundle presented to MEM
- out_ready_i  in  1  MEM accepts
- data1_o, data2_o  out  DATA_W  held operands
- IR_o  out  IR_W  held instruction
- row_o  out  2  00 nop, 01 read (LW), 10 write (SW); 11 never driven
- redirect_o  out  1  one-cycle taken-branch/jump pulse
- redirect_target_o  out  DATA_W  target for redirect_o

## Operation
- Entries: main (drives the outputs) and skid. Each entry holds {data1, data2, IR, row, taken}. Per-entry valid bits are vm and vs.
- Input handshake: in_valid_i && in_ready_o. Output handshake: out_valid_o && out_ready_i.
- Decode runs on the incoming bundle before storage.
  - row = 01 for ALU_LW (0000), 10 for ALU_SW (0001), 00 otherwise.
  - taken = 1 for ALU_J (1000).
  - taken = $signed(data1_i) >= 0 for ALU_BGE (0111). The comparison is signed; a negative data1 is not taken.
- Taken bundle: the stored data1 is replaced by data2_i (the target). The stored data2 and IR are unchanged.
- Redirect: on an accepted, unflushed bundle with taken = 1, redirect_o = 1 for exactly the next cycle and redirect_target_o = data2_i. Otherwise redirect_o = 0. redirect_target_o holds its last value.
- Buffer rules, evaluated per cycle:
  - Push with main empty, or main draining, and skid empty: the bundle goes to main.
  - Push while main is held (out_valid_o && !out_ready_i): the bundle goes to skid.
  - Pop with skid valid: skid moves to main. If a push also occurs, the new bundle goes to skid.
  - Order is strictly FIFO.
- in_ready_o = !vs, registered. It deasserts the cycle after skid fills and reasserts the cycle after skid moves to main.
- Flush has priority over everything. On the next edge vm = vs = 0.
  - A bundle handed over in the same cycle as flush_i is dropped and produces no redirect.
  - A redirect already asserted in the flush cycle still completes.
  - in_ready_o = 1 after a flush.
- The payload of an invalid entry is don't-care. The outputs still hold the last value and do not toggle.

## Timing
- Reset values: out_valid_o = 0, in_ready_o = 1, redirect_o = 0, row_o = 00. data1_o, data2_o, IR_o and redirect_target_o are all zero. Both entries are invalid.
- Reset mid-operation clears everything immediately and asynchronously. The first push is possible on the first edge after rst_n_i rises.
- Latency: accept at edge N gives out_valid_o at N+1 when main is empty or draining. redirect_o is also at N+1.
- Throughput: 1 bundle/cycle with out_ready_i held high.
- Capacity: 2 bundles. in_ready_o falls only when both entries are full.
- Simultaneous push and pop with both entries full cannot happen, because in_ready_o = 0.

## Structure
- Shared package cpu_pkg holds:
  - ALU opcode constants (ALU_LW … ALU_MULI, 4 bits)
  - row encodings ROW_NOP/ROW_RD/ROW_WR
  - the OP_* ALU function codes
- Sub-module ex_mem_decode: combinational; inputs IR and data1; outputs row and taken. It is instantiated once, on the input side.
- The skid/main control lives in ex_mem_pipe itself.

## Test plan
- Reset: hold rst_n_i = 0 → out_valid_o = 0, in_ready_o = 1, redirect_o = 0, row_o = 00. Release, push LW (IR = 0x0000_0000, data1 = 0x40) → next cycle out_valid_o = 1, row_o = 01, data1_o = 0x40.
- Back-pressure: out_ready_i = 0, push SW, then ADDU → in_ready_o = 0 after the second edge. Raise out_ready_i → SW (row_o = 10) pops first, then ADDU (row_o = 00); in_ready_o = 1 the cycle after the first pop.
- BGE signed compare:
  - data1 = 0xFFFF_FFFF, data2 = 0x100 → redirect_o stays 0, data1_o = 0xFFFF_FFFF.
  - data1 = 0, data2 = 0x100 → redirect_o pulses 1 cycle, redirect_target_o = 0x100, data1_o = 0x100.
- J: push IR = 0x8000_0000, data2 = 0x200 → redirect_o = 1 for one cycle, target = 0x200.
- Flush: both entries full, assert flush_i together with a push of a J → next cycle out_valid_o = 0, in_ready_o = 1, no redirect.
- Async reset mid-stream: pulse rst_n_i low between edges with both entries full → out_valid_o = 0 immediately, and no stale bundle appears after release.
